// File: rtl/regfile_sb.sv
// Register file with one write port, two combinational read ports, optional write bypass,
// optional hardwired-zero R0, a per-register pending scoreboard and a sequenced bulk clear.
module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              hz_a,
    output logic              hz_b,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done
);

    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [ADDR_W-1:0]   idx_nx_s;
    logic [DATA_W-1:0]   mem_r [NREGS];
    logic [NREGS-1:0]    pending_r;
    logic [NREGS-1:0]    pend_nx_s;
    logic                clr_done_r;
    logic                idle_s;
    logic                last_s;
    logic                wr_ok_s;
    logic                rsv_ok_s;
    logic                byp_a_s;
    logic                byp_b_s;

    // True when the address names a hardwired-zero R0
    function automatic logic is_r0(input logic [ADDR_W-1:0] addr);
        return (ZERO_R0 != 0) && (addr == '0);
    endfunction

    assign idle_s   = (state_r == IDLE);
    assign last_s   = (idx_r == ADDR_W'(NREGS - 1));
    assign wr_ok_s  = we && idle_s && !is_r0(waddr);
    assign rsv_ok_s = rsv_en && idle_s && !is_r0(rsv_addr);
    assign byp_a_s  = (BYPASS != 0) && wr_ok_s && (waddr == raddr_a);
    assign byp_b_s  = (BYPASS != 0) && wr_ok_s && (waddr == raddr_b);
    assign busy     = (state_r == CLEAR);
    assign clr_done = clr_done_r;

    // Next-state logic of the bulk-clear sequencer
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (clr_start) begin
                    state_nx_s = CLEAR;
                    idx_nx_s   = '0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CLEAR: begin
                if (last_s) begin
                    state_nx_s = IDLE;
                end else begin
                    idx_nx_s = idx_r + ADDR_W'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                idx_nx_s   = '0;
            end
        endcase
    end

    // Sequencer state, sweep index and completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            clr_done_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            idx_r      <= idx_nx_s;
            clr_done_r <= (state_r == CLEAR) && last_s;
        end
    end

    // Register storage: sweep zeroing has priority, writes only while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (state_r == CLEAR) begin
            mem_r[idx_r] <= '0;
        end else if (wr_ok_s) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    // Scoreboard update: a reserve overrides a same-address write (new producer wins)
    always_comb begin
        pend_nx_s = pending_r;
        if (wr_ok_s) begin
            pend_nx_s[waddr] = 1'b0;
        end else begin
            pend_nx_s = pend_nx_s;
        end
        if (rsv_ok_s) begin
            pend_nx_s[rsv_addr] = 1'b1;
        end else begin
            pend_nx_s = pend_nx_s;
        end
        if (idle_s && clr_start) begin
            pend_nx_s = '0;
        end else begin
            pend_nx_s = pend_nx_s;
        end
    end

    // Pending-bit register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= '0;
        end else begin
            pending_r <= pend_nx_s;
        end
    end

    // Read port A with forwarding and hazard flag
    always_comb begin
        rdata_a = mem_r[raddr_a];
        hz_a    = pending_r[raddr_a];
        if (is_r0(raddr_a)) begin
            rdata_a = '0;
            hz_a    = 1'b0;
        end else if (byp_a_s) begin
            rdata_a = wdata;
            hz_a    = 1'b0;
        end else if (!idle_s) begin
            hz_a    = 1'b0;
        end else begin
            hz_a    = pending_r[raddr_a];
        end
    end

    // Read port B with forwarding and hazard flag
    always_comb begin
        rdata_b = mem_r[raddr_b];
        hz_b    = pending_r[raddr_b];
        if (is_r0(raddr_b)) begin
            rdata_b = '0;
            hz_b    = 1'b0;
        end else if (byp_b_s) begin
            rdata_b = wdata;
            hz_b    = 1'b0;
        end else if (!idle_s) begin
            hz_b    = 1'b0;
        end else begin
            hz_b    = pending_r[raddr_b];
        end
    end

endmodule
